perceptron_train_dp: RTL and testbench
======================================

PERCEPTRON_TRAIN_DP -- requirements
Module: perceptron_train_dp

Interface
REQ-001 Parameter WIDTH, default 8: signed input sample width.
REQ-002 Parameter N_IN, default 4: number of inputs (weights), N_IN >= 2.
REQ-003 Parameter WW, default 8: signed weight and bias width.
REQ-004 Parameter LR_SHIFT, default 0: learning-rate right-shift applied to each update term.
REQ-005 Derived constant ACC_W = WIDTH+WW+clog2(N_IN)+1; no other derived widths.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  global clock-enable; low freezes all state.
REQ-009 start_i  in  1  request one inference/training pass.
REQ-010 train_i  in  1  training mode for this pass, sampled with start_i.
REQ-011 target_i  in  1  expected class for this pass, sampled with start_i.
REQ-012 x_i  in  N_IN*WIDTH  packed signed inputs, x[k] = x_i[k*WIDTH +: WIDTH], sampled with start_i.
REQ-013 w_we_i  in  1  weight write strobe.
REQ-014 w_idx_i  in  clog2(N_IN+1)  write target: 0..N_IN-1 = weight k, N_IN = bias.
REQ-015 w_data_i  in  WW  signed write data.
REQ-016 busy_o  out  1  high whenever the FSM is outside IDLE.
REQ-017 done_o  out  1  one-cycle pulse at the end of a pass.
REQ-018 y_o  out  1  registered class result, held until the next done_o.
REQ-019 err_o  out  1  registered flag: y_o != target for the last pass.
REQ-020 acc_o  out  ACC_W  registered signed weighted sum of the last pass.

Function
REQ-021 FSM states are IDLE, MAC, ACT and UPD; while enable=0, state, counters, accumulator, weights and outputs shall hold.
REQ-022 In IDLE, start_i=1 shall latch x_i, train_i and target_i, load acc = sign-extended bias, clear idx, and move to MAC.
REQ-023 In MAC, each enabled cycle shall add x[idx]*w[idx] (full-precision signed) to acc and increment idx; after N_IN cycles, move to ACT.
REQ-024 In ACT, y = (acc >= 0), acc_o <= acc, y_o <= y, err_o <= (y != target).
REQ-025 In ACT, if train=0 or y == target, assert done_o and return to IDLE; otherwise move to UPD.
REQ-026 In UPD, in one cycle, for every k: w[k] <= sat_WW(w[k] + s*(x[k] >>> LR_SHIFT)); bias <= sat_WW(bias + s); s = +1 if target=1, else -1; assert done_o; return to IDLE.
REQ-027 sat_WW clamps to [-2^(WW-1), 2^(WW-1)-1]; the accumulator shall never overflow at ACC_W.
REQ-028 Latency: start accepted at edge 0; done_o is high N_IN+1 enabled cycles later for an inference, N_IN+2 for an update pass.
REQ-029 start_i outside IDLE shall be ignored; a pass is never queued.
REQ-030 w_we_i shall write only in IDLE with no simultaneous start_i; if both occur, start_i wins and the write is dropped; w_idx_i > N_IN is ignored.
REQ-031 Writes to weights outside IDLE shall be ignored.

Reset
REQ-032 reset=0 shall immediately clear FSM to IDLE, all weights and bias to 0, acc, acc_o, y_o, err_o, done_o and busy_o to 0, regardless of enable or current state.
REQ-033 Reset mid-pass shall abort the pass with no weight update and no done_o.

Verification (N_IN=4, WIDTH=8, WW=8, LR_SHIFT=0)
REQ-034 Reset: assert reset=0 mid-MAC -> busy_o=0, done_o=0 and all outputs 0 at once; a subsequent pass with x={1,1,1,1} gives acc_o=0, y_o=1.
REQ-035 Inference: w={1,2,-3,4}, b=-5, x={10,20,5,-1}, train=0 -> done_o on cycle 5, acc_o=26, y_o=1, err_o=0, weights unchanged.
REQ-036 Training: all weights 0, x={3,-2,1,0}, target=0, train=1 -> acc_o=0, y_o=1, err_o=1, done_o on cycle 6, w={-3,2,-1,0}, b=-1.
REQ-037 Saturation: w={100,-128,0,0}, b=0, x={100,100,0,0}, target=1, train=1 -> acc_o=-2800, y_o=0, err_o=1, w={127,-28,0,0}, b=1.
REQ-038 Stall and collision: enable=0 for 3 cycles during MAC -> done_o delayed exactly 3 cycles with the same acc_o; start_i while busy_o=1 -> ignored; start_i with w_we_i in IDLE -> pass runs, weight unchanged.

Source files
------------

// File: rtl/perceptron_train_dp.sv
// Perceptron datapath: serial multiply-accumulate inference over N_IN inputs,
// threshold activation, and an optional single-cycle perceptron weight update
// with saturating arithmetic. Weights and bias are loaded through a write port.
module perceptron_train_dp #(
  parameter int WIDTH    = 8,
  parameter int N_IN     = 4,
  parameter int WW       = 8,
  parameter int LR_SHIFT = 0,
  localparam int ACC_W   = WIDTH + WW + $clog2(N_IN) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start_i,
  input  logic                          train_i,
  input  logic                          target_i,
  input  logic [N_IN*WIDTH-1:0]         x_i,
  input  logic                          w_we_i,
  input  logic [$clog2(N_IN+1)-1:0]     w_idx_i,
  input  logic signed [WW-1:0]          w_data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          y_o,
  output logic                          err_o,
  output logic signed [ACC_W-1:0]       acc_o
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_UPD} state_t;
  typedef logic [$clog2(N_IN)-1:0]   idx_t;
  typedef logic [$clog2(N_IN+1)-1:0] widx_t;

  state_t                  r_state, w_next;
  idx_t                    r_idx;
  logic signed [WIDTH-1:0] r_x [N_IN];
  logic signed [WW-1:0]    r_w [N_IN];
  logic signed [WW-1:0]    r_b;
  logic                    r_train, r_target;
  logic signed [ACC_W-1:0] r_acc, r_acc_o;
  logic                    r_y, r_err, r_done;

  logic                          w_y, w_last, w_upd;
  logic signed [WIDTH-1:0]       w_x_sel;
  logic signed [WW-1:0]          w_w_sel;
  logic signed [WIDTH+WW-1:0]    w_prod;
  logic signed [ACC_W-1:0]       w_prod_ext;
  logic signed [WW-1:0]          w_w_new [N_IN];
  logic signed [WW-1:0]          w_b_new;

  function automatic logic signed [ACC_W-1:0] ext_w(input logic signed [WW-1:0] v);
    return {{(ACC_W-WW){v[WW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_x(input logic signed [WIDTH-1:0] v);
    return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // Clamp a wide signed value into the WW-bit signed weight range.
  function automatic logic signed [WW-1:0] sat_ww(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi, lo;
    hi = {{(ACC_W-WW+1){1'b0}}, {(WW-1){1'b1}}};
    lo = {{(ACC_W-WW+1){1'b1}}, {(WW-1){1'b0}}};
    if (v > hi)      sat_ww = {1'b0, {(WW-1){1'b1}}};
    else if (v < lo) sat_ww = {1'b1, {(WW-1){1'b0}}};
    else             sat_ww = v[WW-1:0];
  endfunction

  // Current MAC term: sign-extend both operands so the product is full precision.
  assign w_x_sel    = r_x[r_idx];
  assign w_w_sel    = r_w[r_idx];
  assign w_prod     = {{WW{w_x_sel[WIDTH-1]}}, w_x_sel} * {{WIDTH{w_w_sel[WW-1]}}, w_w_sel};
  assign w_prod_ext = {{(ACC_W-WIDTH-WW){w_prod[WIDTH+WW-1]}}, w_prod};

  assign w_y    = ~r_acc[ACC_W-1];
  assign w_last = (r_idx == idx_t'(N_IN-1));
  assign w_upd  = r_train && (w_y != r_target);

  // Candidate weights and bias after one perceptron step toward the target.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    w_b_new = sat_ww(ext_w(r_b) + (r_target ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}}));
    for (int k = 0; k < N_IN; k++) begin
      w_w_new[k] = sat_ww(ext_w(r_w[k]) + (r_target ? ext_x(r_x[k] >>> LR_SHIFT)
                                                    : -ext_x(r_x[k] >>> LR_SHIFT)));
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_MAC;
      S_MAC:   if (w_last)  w_next = S_ACT;
      S_ACT:   w_next = w_upd ? S_UPD : S_IDLE;
      S_UPD:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, frozen while enable is low.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset)      r_state <= S_IDLE;
    else if (enable) r_state <= w_next;
  end

  // Datapath registers: sample, accumulate, activate, update, and host weight writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the weight file is small and must come up cleared, so it is reset like ordinary flops.
      for (int k = 0; k < N_IN; k++) begin
        r_w[k] <= '0;
        r_x[k] <= '0;
      end
      r_b      <= '0;
      r_idx    <= '0;
      r_train  <= 1'b0;
      r_target <= 1'b0;
      r_acc    <= '0;
      r_acc_o  <= '0;
      r_y      <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            for (int k = 0; k < N_IN; k++) r_x[k] <= x_i[k*WIDTH +: WIDTH];
            r_train  <= train_i;
            r_target <= target_i;
            r_acc    <= ext_w(r_b);
            r_idx    <= '0;
          end else if (w_we_i) begin
            // A start in the same cycle takes priority and drops the write.
            if (w_idx_i < widx_t'(N_IN))       r_w[w_idx_i[$clog2(N_IN)-1:0]] <= w_data_i;
            else if (w_idx_i == widx_t'(N_IN)) r_b <= w_data_i;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_idx <= r_idx + 1'b1;
        end
        S_ACT: begin
          r_acc_o <= r_acc;
          r_y     <= w_y;
          r_err   <= (w_y != r_target);
          r_done  <= ~w_upd;
        end
        S_UPD: begin
          for (int k = 0; k < N_IN; k++) r_w[k] <= w_w_new[k];
          r_b    <= w_b_new;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (r_state != S_IDLE);
  assign done_o = r_done;
  assign y_o    = r_y;
  assign err_o  = r_err;
  assign acc_o  = r_acc_o;

endmodule

// File: tb/tb_perceptron_train_dp.sv
// Directed bench for perceptron_train_dp (N_IN=4, WIDTH=8, WW=8, LR_SHIFT=0).
// Weights are not directly visible, so they are read back through inference
// passes: x=0 yields the bias, x=e_k yields w[k]+bias.
module tb_perceptron_train_dp;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b1;
  logic              start_i = 1'b0;
  logic              train_i = 1'b0;
  logic              target_i = 1'b0;
  logic [31:0]       x_i = '0;
  logic              w_we_i = 1'b0;
  logic [2:0]        w_idx_i = '0;
  logic signed [7:0] w_data_i = '0;
  logic              busy_o, done_o, y_o, err_o;
  logic [18:0]       acc_o;

  int total = 0;
  int bad   = 0;
  int probe_w [4];
  int probe_b;

  perceptron_train_dp #(.WIDTH(8), .N_IN(4), .WW(8), .LR_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start_i(start_i),
    .train_i(train_i), .target_i(target_i), .x_i(x_i), .w_we_i(w_we_i),
    .w_idx_i(w_idx_i), .w_data_i(w_data_i), .busy_o(busy_o), .done_o(done_o),
    .y_o(y_o), .err_o(err_o), .acc_o(acc_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int acc_int();
    return int'($signed(acc_o));
  endfunction

  task automatic write_w(input int idx, input int val);
    w_we_i = 1'b1; w_idx_i = 3'(idx); w_data_i = 8'(val);
    tick;
    w_we_i = 1'b0;
  endtask

  task automatic load_w(input int a, input int b, input int c, input int d, input int bias);
    write_w(0, a); write_w(1, b); write_w(2, c); write_w(3, d); write_w(4, bias);
  endtask

  // Start one pass and count cycles after the accepting edge until done_o.
  task automatic run_pass(input logic [31:0] x, input logic tr, input logic tg, output int cyc);
    x_i = x; train_i = tr; target_i = tg; start_i = 1'b1;
    tick;
    start_i = 1'b0; w_we_i = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      tick;
      cyc++;
      if (done_o) break;
    end
    total++;
    if (done_o !== 1'b1) begin
      bad++;
      $display("FAIL pass_timeout: done_o=%b after %0d cycles, required 1", done_o, cyc);
    end
  endtask

  task automatic probe;
    int c;
    run_pass(32'h0, 1'b0, 1'b0, c);
    probe_b = acc_int();
    for (int k = 0; k < 4; k++) begin
      run_pass(32'h1 << (8 * k), 1'b0, 1'b0, c);
      probe_w[k] = acc_int() - probe_b;
    end
  endtask

  task automatic test_reset;
    int c;
    #12;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_o); end
    total++; if (acc_o !== 19'd0) begin bad++; $display("FAIL rst_acc: got %0d want 0", acc_int()); end
    @(negedge clk) reset = 1'b1;
    load_w(1, 2, 3, 4, 5);
    run_pass(pack4(1, 1, 1, 1), 1'b0, 1'b0, c);
    total++; if (acc_int() !== 15) begin bad++; $display("FAIL pre_acc: got %0d want 15", acc_int()); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL pre_err: got %b want 1", err_o); end
    // Second pass, aborted by reset in the middle of MAC.
    x_i = pack4(1, 1, 1, 1); train_i = 1'b1; target_i = 1'b0; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick; tick;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy_o); end
    #2 reset = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done_o); end
    total++; if (y_o !== 1'b0) begin bad++; $display("FAIL abort_y: got %b want 0", y_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", err_o); end
    total++; if (acc_o !== 19'd0) begin bad++; $display("FAIL abort_acc: got %0d want 0", acc_int()); end
    @(negedge clk); @(negedge clk);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done_hold: got %b want 0", done_o); end
    reset = 1'b1;
    // Weights were cleared by reset, so the sum is zero and y is 1.
    run_pass(pack4(1, 1, 1, 1), 1'b0, 1'b1, c);
    total++; if (acc_int() !== 0) begin bad++; $display("FAIL post_acc: got %0d want 0", acc_int()); end
    total++; if (y_o !== 1'b1) begin bad++; $display("FAIL post_y: got %b want 1", y_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL post_err: got %b want 0", err_o); end
  endtask

  task automatic test_inference;
    int c;
    int exp_w [4] = '{1, 2, -3, 4};
    load_w(1, 2, -3, 4, -5);
    run_pass(pack4(10, 20, 5, -1), 1'b0, 1'b1, c);
    total++; if (c !== 5) begin bad++; $display("FAIL inf_latency: got %0d want 5", c); end
    total++; if (acc_int() !== 26) begin bad++; $display("FAIL inf_acc: got %0d want 26", acc_int()); end
    total++; if (y_o !== 1'b1) begin bad++; $display("FAIL inf_y: got %b want 1", y_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL inf_err: got %b want 0", err_o); end
    tick;
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL inf_done_pulse: got %b want 0", done_o); end
    total++; if (y_o !== 1'b1) begin bad++; $display("FAIL inf_y_hold: got %b want 1", y_o); end
    probe;
    total++; if (probe_b !== -5) begin bad++; $display("FAIL inf_bias: got %0d want -5", probe_b); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (probe_w[k] !== exp_w[k]) begin bad++; $display("FAIL inf_w%0d: got %0d want %0d", k, probe_w[k], exp_w[k]); end
    end
  endtask

  task automatic test_training;
    int c;
    int exp_w [4] = '{-3, 2, -1, 0};
    load_w(0, 0, 0, 0, 0);
    run_pass(pack4(3, -2, 1, 0), 1'b1, 1'b0, c);
    total++; if (c !== 6) begin bad++; $display("FAIL trn_latency: got %0d want 6", c); end
    total++; if (acc_int() !== 0) begin bad++; $display("FAIL trn_acc: got %0d want 0", acc_int()); end
    total++; if (y_o !== 1'b1) begin bad++; $display("FAIL trn_y: got %b want 1", y_o); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL trn_err: got %b want 1", err_o); end
    probe;
    total++; if (probe_b !== -1) begin bad++; $display("FAIL trn_bias: got %0d want -1", probe_b); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (probe_w[k] !== exp_w[k]) begin bad++; $display("FAIL trn_w%0d: got %0d want %0d", k, probe_w[k], exp_w[k]); end
    end
  endtask

  task automatic test_saturation;
    int c;
    int exp_w [4] = '{127, -28, 0, 0};
    load_w(100, -128, 0, 0, 0);
    run_pass(pack4(100, 100, 0, 0), 1'b1, 1'b1, c);
    total++; if (c !== 6) begin bad++; $display("FAIL sat_latency: got %0d want 6", c); end
    total++; if (acc_int() !== -2800) begin bad++; $display("FAIL sat_acc: got %0d want -2800", acc_int()); end
    total++; if (y_o !== 1'b0) begin bad++; $display("FAIL sat_y: got %b want 0", y_o); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL sat_err: got %b want 1", err_o); end
    probe;
    total++; if (probe_b !== 1) begin bad++; $display("FAIL sat_bias: got %0d want 1", probe_b); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (probe_w[k] !== exp_w[k]) begin bad++; $display("FAIL sat_w%0d: got %0d want %0d", k, probe_w[k], exp_w[k]); end
    end
  endtask

  task automatic test_stall;
    int  n;
    logic busy_seen;
    load_w(1, 2, -3, 4, -5);
    x_i = pack4(10, 20, 5, -1); train_i = 1'b0; target_i = 1'b1; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n = 0;
    busy_seen = 1'b0;
    while (n < 20) begin
      enable = (n >= 1 && n <= 3) ? 1'b0 : 1'b1;
      tick;
      n++;
      if (n == 3) busy_seen = busy_o;
      if (done_o) break;
    end
    enable = 1'b1;
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL stall_timeout: done_o=%b after %0d cycles", done_o, n); end
    total++; if (n !== 8) begin bad++; $display("FAIL stall_latency: got %0d want 8", n); end
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b want 1", busy_seen); end
    total++; if (acc_int() !== 26) begin bad++; $display("FAIL stall_acc: got %0d want 26", acc_int()); end
  endtask

  task automatic test_back_to_back;
    int  n, c;
    logic busy_after;
    int exp_w [4] = '{1, 2, -3, 4};
    // Weights still {1,2,-3,4}, bias -5 from the stall test.
    x_i = pack4(10, 20, 5, -1); train_i = 1'b0; target_i = 1'b1; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    n = 0;
    while (n < 20) begin
      if (n == 1) begin
        // A second start plus a weight write while busy must both be ignored.
        start_i = 1'b1; x_i = pack4(1, 1, 1, 1); train_i = 1'b1; target_i = 1'b0;
        w_we_i = 1'b1; w_idx_i = 3'd1; w_data_i = 8'sd99;
      end else begin
        start_i = 1'b0; w_we_i = 1'b0;
      end
      tick;
      n++;
      if (done_o) break;
    end
    start_i = 1'b0; w_we_i = 1'b0;
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_latency: got %0d want 5", n); end
    total++; if (acc_int() !== 26) begin bad++; $display("FAIL b2b_acc: got %0d want 26", acc_int()); end
    busy_after = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      busy_after = busy_after | busy_o;
    end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL b2b_queued: busy seen=%b want 0", busy_after); end
    // Start and write in the same IDLE cycle: the pass runs, the write is dropped.
    w_we_i = 1'b1; w_idx_i = 3'd0; w_data_i = 8'sd50;
    run_pass(pack4(1, 1, 1, 1), 1'b0, 1'b1, c);
    total++; if (c !== 5) begin bad++; $display("FAIL coll_latency: got %0d want 5", c); end
    total++; if (acc_int() !== -1) begin bad++; $display("FAIL coll_acc: got %0d want -1", acc_int()); end
    total++; if (y_o !== 1'b0) begin bad++; $display("FAIL coll_y: got %b want 0", y_o); end
    // Out-of-range write indices are ignored.
    write_w(5, 77); write_w(6, 77); write_w(7, 77);
    probe;
    total++; if (probe_b !== -5) begin bad++; $display("FAIL coll_bias: got %0d want -5", probe_b); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (probe_w[k] !== exp_w[k]) begin bad++; $display("FAIL coll_w%0d: got %0d want %0d", k, probe_w[k], exp_w[k]); end
    end
  endtask

  initial begin
    test_reset;
    test_inference;
    test_training;
    test_saturation;
    test_stall;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
